id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode stage plus ID/EX pipeline register of the RISC-V core. It sits directly upstream of alu_control.
//  - Decodes the opcode into main control signals, including the 2-bit ALUOp.
//  - Registers the instruction and its controls for EX, where alu_control consumes ex_instruction and ex_alu_op.
//  - Provides a valid/ready handshake, synchronous flush, and load-use hazard bubble insertion.
// PARAMETERS
//  XLEN      32  data/PC width
//  CNT_W     16  width of saturating stall counter
// PORTS
//  clk            in   1      single core clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  in_valid       in   1      IF/ID holds a valid instruction
//  in_ready       out  1      stage accepts instruction this cycle
//  in_instr       in   32     instruction word from IF/ID
//  in_pc          in   XLEN   PC of in_instr
//  flush          in   1      synchronous kill of EX register and of incoming instr
//  out_ready      in   1      EX consumes current EX register contents
//  ex_valid       out  1      EX register holds a real instruction
//  ex_instruction out  32     registered instruction (to alu_control.instruction)
//  ex_pc          out  XLEN   registered PC
//  ex_alu_op      out  2      00 ld/st add, 01 branch sub, 10 R-type, 11 I-type ALU
//  ex_reg_write   out  1      write rd
//  ex_mem_read    out  1      load
//  ex_mem_write   out  1      store
//  ex_alu_src     out  1      1 = immediate operand
//  ex_mem_to_reg  out  1      writeback from memory
//  ex_branch      out  1      conditional branch
//  ex_rd          out  5      instr[11:7]; forced 0 for store/branch
//  stall_count    out  CNT_W  load-use bubbles inserted, saturating
//  illegal        out  1      sticky illegal-opcode flag (only with macro)
// BEHAVIOUR
//  - Reset (async, rst_n=0): every ex_* output = 0, ex_valid = 0, stall_count = 0, illegal = 0.
//  - Decode by opcode in_instr[6:0]:
//    R 0110011 -> op10, rw=1.
//    I 0010011 -> op11, rw=1, src=1.
//    LOAD 0000011 -> op00, rw=1, src=1, mr=1, m2r=1.
//    STORE 0100011 -> op00, src=1, mw=1.
//    BRANCH 1100011 -> op01, br=1.
//    Any other opcode is illegal.
//  - Source use: R/STORE/BRANCH use rs1 [19:15] and rs2 [24:20]; I/LOAD use rs1 only.
//  - hazard = in_valid & ex_valid & ex_mem_read & ex_rd != 0 & (ex_rd matches a used rs).
//  - adv = !ex_valid | out_ready.
//  - in_ready = flush | (adv & !hazard).
//  - Priority each rising edge:
//    (1) flush: ex_valid <= 0, all controls <= 0; the incoming instr is accepted and dropped.
//    (2) adv & hazard: bubble, i.e. ex_valid <= 0 and controls <= 0; stall_count++ (holds at all-ones).
//    (3) adv & in_valid: load EX register with decoded controls; ex_valid <= 1.
//    (4) adv & !in_valid: ex_valid <= 0.
//    (5) !adv: hold all ex_* stable.
//  - Latency: 1 cycle from accept to ex_valid.
//  - Back-to-back issue at full rate when out_ready = 1 and no hazard.
//  - Bubbles and flushed entries always carry all-zero controls, so no side effects occur downstream.
//  - Hazard persists for exactly one bubble: after the bubble the load has left EX and the consumer is accepted next cycle.
//  - rd = x0 never creates a hazard.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//   - An illegal opcode is accepted, replaced by a bubble (ex_valid = 0), and sets sticky illegal = 1.
//   - illegal is cleared only by reset; flush does not clear it.
//  ILLEGAL_TRAP_EN undefined:
//   - An illegal opcode passes as a valid NOP (ex_valid = 1, all controls 0, ex_rd = 0).
//   - The illegal port is absent.
// TESTING
//  T1 reset mid-stream: rst_n=0 while ex_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
//  T2 add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle ex_valid=1, op=10, rw=1, rd=3.
//  T3 lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333):
//     - one bubble: in_ready=0 for 1 cycle;
//     - add reaches EX 2 cycles after lw;
//     - stall_count=1.
//  T4 lw x0,0(x1) (0x0000A003) then add x6,x0,x2 (0x00200333) -> no bubble, stall_count stays 0.
//  T5 out_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, in_ready=0; release -> next instr loads.
//  T6 flush during T3 stall -> ex_valid=0 next cycle, in_ready=1 that cycle;
//     0x0000007F -> illegal=1 (macro on) or valid NOP (macro off).

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bus: IF/ID handshake in, registered EX controls out.
// master drives the instruction stream and EX acceptance; slave is the stage.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_ready;
    logic            ex_valid;
    logic [31:0]     ex_instruction;
    logic [XLEN-1:0] ex_pc;
    logic [1:0]      ex_alu_op;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_alu_src;
    logic            ex_mem_to_reg;
    logic            ex_branch;
    logic [4:0]      ex_rd;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, ex_valid, ex_instruction, ex_pc, ex_alu_op, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg, ex_branch, ex_rd
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, ex_valid, ex_instruction, ex_pc, ex_alu_op, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg, ex_branch, ex_rd
    );
endinterface

// File: rtl/id_ex_stage.sv
// RV decode + ID/EX register with load-use bubble and flush; ILLEGAL_TRAP_EN turns bad opcodes into bubbles + sticky flag.
// Latency: 1 cycle from accept to ex_valid; full rate when out_ready=1 and no hazard.
// Backpressure: EX register holds while ex_valid & !out_ready; in_ready drops on hold or load-use hazard.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] stall_count
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       branch;
        logic [4:0] rd;
    } ctrl_t;

    ctrl_t           dec_ctrl, nxt_ctrl, ex_ctrl;
    logic            legal, use_rs1, use_rs2;
    logic            hazard, adv, upd, bump, illegal_set;
    logic            ex_valid_q, nxt_valid;
    logic [31:0]     ex_instr_q, nxt_instr;
    logic [XLEN-1:0] ex_pc_q, nxt_pc;

    always_comb begin
        dec_ctrl = '0;
        legal    = 1'b1;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (bus.in_instr[6:0])
            OP_R: begin
                dec_ctrl.alu_op    = 2'b10;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.rd        = bus.in_instr[11:7];
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
            end
            OP_I: begin
                dec_ctrl.alu_op    = 2'b11;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.rd        = bus.in_instr[11:7];
                use_rs1            = 1'b1;
            end
            OP_LOAD: begin
                dec_ctrl.alu_op     = 2'b00;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.rd         = bus.in_instr[11:7];
                use_rs1             = 1'b1;
            end
            OP_STORE: begin
                dec_ctrl.alu_op    = 2'b00;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
            end
            OP_BRANCH: begin
                dec_ctrl.alu_op = 2'b01;
                dec_ctrl.branch = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // ex_rd is already zero for non-writers, so only a load with a real rd can stall
    assign hazard = bus.in_valid & ex_valid_q & ex_ctrl.mem_read & (ex_ctrl.rd != 5'd0) &
                    ((use_rs1 & (bus.in_instr[19:15] == ex_ctrl.rd)) |
                     (use_rs2 & (bus.in_instr[24:20] == ex_ctrl.rd)));
    assign adv          = !ex_valid_q | bus.out_ready;
    assign upd          = bus.flush | adv;
    assign bump         = !bus.flush & adv & hazard;
    assign bus.in_ready = bus.flush | (adv & !hazard);

    always_comb begin
        nxt_valid   = 1'b0;
        nxt_ctrl    = '0;
        nxt_instr   = '0;
        nxt_pc      = '0;
        illegal_set = 1'b0;
        if (!bus.flush && !hazard && bus.in_valid) begin
            if (legal) begin
                nxt_valid = 1'b1;
                nxt_ctrl  = dec_ctrl;
                nxt_instr = bus.in_instr;
                nxt_pc    = bus.in_pc;
            end else begin
`ifdef ILLEGAL_TRAP_EN
                illegal_set = 1'b1;
`else
                nxt_valid = 1'b1;
                nxt_instr = bus.in_instr;
                nxt_pc    = bus.in_pc;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl     <= '0;
            ex_instr_q  <= '0;
            ex_pc_q     <= '0;
            stall_count <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else begin
            if (upd) begin
                ex_valid_q <= nxt_valid;
                ex_ctrl    <= nxt_ctrl;
                ex_instr_q <= nxt_instr;
                ex_pc_q    <= nxt_pc;
            end
            if (bump && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
`ifdef ILLEGAL_TRAP_EN
            if (upd && illegal_set)
                illegal <= 1'b1;
`endif
        end
    end

    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_instruction = ex_instr_q;
    assign bus.ex_pc          = ex_pc_q;
    assign bus.ex_alu_op      = ex_ctrl.alu_op;
    assign bus.ex_reg_write   = ex_ctrl.reg_write;
    assign bus.ex_mem_read    = ex_ctrl.mem_read;
    assign bus.ex_mem_write   = ex_ctrl.mem_write;
    assign bus.ex_alu_src     = ex_ctrl.alu_src;
    assign bus.ex_mem_to_reg  = ex_ctrl.mem_to_reg;
    assign bus.ex_branch      = ex_ctrl.branch;
    assign bus.ex_rd          = ex_ctrl.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: a stream table plus hand sequences for
// stall-counter saturation, sticky illegal flag and asynchronous reset.
module tb_id_ex_stage;
    localparam logic [31:0] ADD3  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] ADDI7 = 32'h00508393; // addi x7,x1,5 (rs2 field = 5, unused)
    localparam logic [31:0] SW    = 32'h0020A223; // sw x2,4(x1)
    localparam logic [31:0] BEQ   = 32'h00208463; // beq x1,x2
    localparam logic [31:0] LW5   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] ADD6  = 32'h00228333; // add x6,x5,x2
    localparam logic [31:0] LW0   = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] ADD60 = 32'h00200333; // add x6,x0,x2
    localparam logic [31:0] SW5   = 32'h0050A023; // sw x5,0(x1)
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] PCX   = 32'hA5A5_0000;
    // flags = {reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch}
    localparam logic [5:0] FR = 6'b100000, FI = 6'b100100, FL = 6'b110110;
    localparam logic [5:0] FS = 6'b001100, FB = 6'b000001, FZ = 6'b000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] stall_count;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif
    int         n_vec = 0;
    int         n_err = 0;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stall_count (stall_count)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic        ordy;
        logic        fl;
        logic        e_rdy;
        logic        e_vld;
        logic        ctl_chk;
        logic [31:0] e_instr;
        logic [1:0]  e_op;
        logic [5:0]  e_fl;
        logic [4:0]  e_rd;
        logic [2:0]  e_stall;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t v(input logic iv, input logic [31:0] instr, input logic ordy,
                               input logic fl, input logic rdy, input logic vld, input logic cc,
                               input logic [31:0] ei, input logic [1:0] op, input logic [5:0] f6,
                               input logic [4:0] rd, input logic [2:0] st);
        vec_t r;
        r.iv = iv; r.instr = instr; r.ordy = ordy; r.fl = fl; r.e_rdy = rdy; r.e_vld = vld;
        r.ctl_chk = cc; r.e_instr = ei; r.e_op = op; r.e_fl = f6; r.e_rd = rd; r.e_stall = st;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                bus.ex_alu_src, bus.ex_mem_to_reg, bus.ex_branch};
    endfunction

    task automatic apply(input vec_t t, input string nm);
        @(negedge clk);
        bus.in_valid  = t.iv;
        bus.in_instr  = t.instr;
        bus.in_pc     = t.instr ^ PCX;
        bus.out_ready = t.ordy;
        bus.flush     = t.fl;
        #1;
        chk({nm, " in_ready"}, 32'(bus.in_ready), 32'(t.e_rdy));
        @(posedge clk);
        #1;
        chk({nm, " ex_valid"}, 32'(bus.ex_valid), 32'(t.e_vld));
        if (t.ctl_chk) begin
            chk({nm, " alu_op"}, 32'(bus.ex_alu_op), 32'(t.e_op));
            chk({nm, " flags"}, 32'(flags()), 32'(t.e_fl));
            chk({nm, " rd"}, 32'(bus.ex_rd), 32'(t.e_rd));
        end
        if (t.e_vld) begin
            chk({nm, " instr"}, bus.ex_instruction, t.e_instr);
            chk({nm, " pc"}, bus.ex_pc, t.e_instr ^ PCX);
        end
        chk({nm, " stall"}, 32'(stall_count), 32'(t.e_stall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;

        tab.push_back(v(1, ADD3,  1, 0, 1, 1, 1, ADD3,  2'b10, FR, 5'd3, 3'd0)); // T2
        tab.push_back(v(1, ADDI7, 1, 0, 1, 1, 1, ADDI7, 2'b11, FI, 5'd7, 3'd0));
        tab.push_back(v(1, SW,    1, 0, 1, 1, 1, SW,    2'b00, FS, 5'd0, 3'd0));
        tab.push_back(v(1, BEQ,   1, 0, 1, 1, 1, BEQ,   2'b01, FB, 5'd0, 3'd0));
        tab.push_back(v(1, LW5,   1, 0, 1, 1, 1, LW5,   2'b00, FL, 5'd5, 3'd0)); // T3
        tab.push_back(v(1, ADD6,  1, 0, 0, 0, 1, 32'd0, 2'b00, FZ, 5'd0, 3'd1));
        tab.push_back(v(1, ADD6,  1, 0, 1, 1, 1, ADD6,  2'b10, FR, 5'd6, 3'd1));
        tab.push_back(v(1, LW5,   1, 0, 1, 1, 1, LW5,   2'b00, FL, 5'd5, 3'd1));
        tab.push_back(v(1, ADDI7, 1, 0, 1, 1, 1, ADDI7, 2'b11, FI, 5'd7, 3'd1));
        tab.push_back(v(1, LW0,   1, 0, 1, 1, 1, LW0,   2'b00, FL, 5'd0, 3'd1)); // T4
        tab.push_back(v(1, ADD60, 1, 0, 1, 1, 1, ADD60, 2'b10, FR, 5'd6, 3'd1));
        tab.push_back(v(0, ADD3,  1, 0, 1, 0, 0, 32'd0, 2'b00, FZ, 5'd0, 3'd1));
        tab.push_back(v(1, LW5,   1, 0, 1, 1, 1, LW5,   2'b00, FL, 5'd5, 3'd1));
        tab.push_back(v(1, SW5,   1, 0, 0, 0, 1, 32'd0, 2'b00, FZ, 5'd0, 3'd2));
        tab.push_back(v(1, SW5,   1, 0, 1, 1, 1, SW5,   2'b00, FS, 5'd0, 3'd2));
        tab.push_back(v(1, ADD3,  1, 0, 1, 1, 1, ADD3,  2'b10, FR, 5'd3, 3'd2)); // T5
        for (int k = 0; k < 3; k++)
            tab.push_back(v(1, ADDI7, 0, 0, 0, 1, 1, ADD3, 2'b10, FR, 5'd3, 3'd2));
        tab.push_back(v(1, ADDI7, 1, 0, 1, 1, 1, ADDI7, 2'b11, FI, 5'd7, 3'd2));
`ifdef ILLEGAL_TRAP_EN
        tab.push_back(v(1, ILL,   1, 0, 1, 0, 1, 32'd0, 2'b00, FZ, 5'd0, 3'd2));
`else
        tab.push_back(v(1, ILL,   1, 0, 1, 1, 1, ILL,   2'b00, FZ, 5'd0, 3'd2));
`endif
        tab.push_back(v(1, LW5,   1, 0, 1, 1, 1, LW5,   2'b00, FL, 5'd5, 3'd2)); // T6
        tab.push_back(v(1, ADD6,  1, 1, 1, 0, 1, 32'd0, 2'b00, FZ, 5'd0, 3'd2));
        tab.push_back(v(1, ADD6,  1, 0, 1, 1, 1, ADD6,  2'b10, FR, 5'd6, 3'd2));
        tab.push_back(v(1, ADDI7, 0, 1, 1, 0, 1, 32'd0, 2'b00, FZ, 5'd0, 3'd2));

        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset stall", 32'(stall_count), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
`ifdef ILLEGAL_TRAP_EN
        chk("reset illegal", 32'(illegal), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tab.size(); i++)
            apply(tab[i], $sformatf("v%0d", i));

`ifdef ILLEGAL_TRAP_EN
        chk("illegal sticky past flush", 32'(illegal), 32'd1);
`endif

        // repeated load-use pairs push the 3-bit counter into saturation
        for (int i = 0; i < 6; i++) begin
            int s0, s1;
            s0 = (2 + i > 7) ? 7 : 2 + i;
            s1 = (3 + i > 7) ? 7 : 3 + i;
            apply(v(1, LW5,  1, 0, 1, 1, 1, LW5,   2'b00, FL, 5'd5, 3'(s0)), $sformatf("sat%0d lw", i));
            apply(v(1, ADD6, 1, 0, 0, 0, 1, 32'd0, 2'b00, FZ, 5'd0, 3'(s1)), $sformatf("sat%0d bubble", i));
            apply(v(1, ADD6, 1, 0, 1, 1, 1, ADD6,  2'b10, FR, 5'd6, 3'(s1)), $sformatf("sat%0d add", i));
        end
        chk("stall saturated", 32'(stall_count), 32'd7);

        // T1: asynchronous reset while EX holds a valid add
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("pre-reset ex_valid", 32'(bus.ex_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("async alu_op", 32'(bus.ex_alu_op), 32'd0);
        chk("async flags", 32'(flags()), 32'd0);
        chk("async rd", 32'(bus.ex_rd), 32'd0);
        chk("async instr", bus.ex_instruction, 32'd0);
        chk("async pc", bus.ex_pc, 32'd0);
        chk("async stall", 32'(stall_count), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        chk("async illegal", 32'(illegal), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        apply(v(1, ADD3, 1, 0, 1, 1, 1, ADD3, 2'b10, FR, 5'd3, 3'd0), "post-reset add");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
